// File: rtl/grf_pkg.sv
// Shared constants and helpers for the register file with busy-bit scoreboard.
// Helper functions work on maximum-width vectors; callers zero-extend into them.
package grf_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int ADDR_W_DEF = 5;
    localparam int NUM_RD_DEF = 2;
    localparam int NUM_WR_DEF = 1;

    localparam int MAX_WR     = 8;
    localparam int MAX_ADDR_W = 8;
    localparam int MAX_REGS   = 256;
    localparam int IDX_W      = 3;

    typedef struct packed {
        logic             hit;
        logic [IDX_W-1:0] idx;
    } match_t;

    function automatic int unsigned popcount(input logic [MAX_REGS-1:0] v);
        int unsigned n;
        n = 0;
        for (int k = 0; k < MAX_REGS; k++) begin
            n += {31'd0, v[k]};
        end
        return n;
    endfunction

    // Later ports overwrite earlier hits, so the highest-index matching port wins.
    function automatic match_t match_last(input logic [MAX_WR-1:0]            en,
                                          input logic [MAX_WR*MAX_ADDR_W-1:0] addrs,
                                          input logic [MAX_ADDR_W-1:0]        addr);
        match_t m;
        m = '0;
        if (addr != '0) begin
            for (int j = 0; j < MAX_WR; j++) begin
                if (en[j] && addrs[j*MAX_ADDR_W +: MAX_ADDR_W] == addr) begin
                    m.hit = 1'b1;
                    m.idx = IDX_W'(j);
                end
            end
        end
        return m;
    endfunction

endpackage

// File: rtl/grf_sb_bypass.sv
// One read port: selects same-cycle write data over stored data and reports
// whether a write hit occurred so the caller can mask the busy bit.
module grf_bypass
    import grf_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int NUM_WR = NUM_WR_DEF
) (
    input  logic [ADDR_W-1:0]        rd_addr_i,
    input  logic [DATA_W-1:0]        stored_data_i,
    input  logic [NUM_WR-1:0]        wr_en_i,
    input  logic [NUM_WR*ADDR_W-1:0] wr_addr_i,
    input  logic [NUM_WR*DATA_W-1:0] wr_data_i,
    output logic [DATA_W-1:0]        rd_data_o,
    output logic                     wr_hit_o
);

    logic [MAX_WR-1:0]            en_ext;
    logic [MAX_WR*MAX_ADDR_W-1:0] addr_ext;
    logic [MAX_ADDR_W-1:0]        ra_ext;
    match_t                       m;
    logic [DATA_W-1:0]            byp_data;

    always_comb begin
        en_ext   = '0;
        addr_ext = '0;
        ra_ext   = '0;
        en_ext[NUM_WR-1:0]   = wr_en_i;
        ra_ext[ADDR_W-1:0]   = rd_addr_i;
        for (int j = 0; j < NUM_WR; j++) begin
            addr_ext[j*MAX_ADDR_W +: ADDR_W] = wr_addr_i[j*ADDR_W +: ADDR_W];
        end
        m = match_last(en_ext, addr_ext, ra_ext);

        byp_data = '0;
        for (int j = 0; j < NUM_WR; j++) begin
            if (int'(m.idx) == j) begin
                byp_data = wr_data_i[j*DATA_W +: DATA_W];
            end
        end

        wr_hit_o = m.hit;
        if (rd_addr_i == '0) begin
            rd_data_o = '0;
        end else if (m.hit) begin
            rd_data_o = byp_data;
        end else begin
            rd_data_o = stored_data_i;
        end
    end

endmodule

// File: rtl/grf_sb.sv
// Multi-port register file (r0 hardwired to zero) with write-to-read bypass and
// a per-register busy scoreboard driven by claims, writebacks and flush.
module grf_sb
    import grf_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int NUM_RD = NUM_RD_DEF,
    parameter int NUM_WR = NUM_WR_DEF
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
    output logic [NUM_RD-1:0]        rd_busy,
    input  logic [NUM_WR-1:0]        wr_en,
    input  logic [NUM_WR*ADDR_W-1:0] wr_addr,
    input  logic [NUM_WR*DATA_W-1:0] wr_data,
    input  logic                     claim_en,
    input  logic [ADDR_W-1:0]        claim_addr,
    input  logic                     flush,
    output logic [ADDR_W:0]          busy_cnt
);

    localparam int DEPTH = 2**ADDR_W;

    logic [DATA_W-1:0]   regs_q [DEPTH];
    logic [DATA_W-1:0]   regs_d [DEPTH];
    logic [DEPTH-1:0]    busy_q, busy_d;
    logic [ADDR_W:0]     busy_cnt_q, busy_cnt_d;
    logic [MAX_REGS-1:0] busy_ext;

    // Ports applied in index order so the highest-index port wins a conflict.
    always_comb begin
        regs_d = regs_q;
        for (int j = 0; j < NUM_WR; j++) begin
            if (wr_en[j] && wr_addr[j*ADDR_W +: ADDR_W] != '0) begin
                regs_d[wr_addr[j*ADDR_W +: ADDR_W]] = wr_data[j*DATA_W +: DATA_W];
            end
        end
    end

    // Applied lowest priority first: writeback clear, then claim, then flush.
    always_comb begin
        busy_d = busy_q;
        for (int j = 0; j < NUM_WR; j++) begin
            if (wr_en[j]) begin
                busy_d[wr_addr[j*ADDR_W +: ADDR_W]] = 1'b0;
            end
        end
        if (claim_en && claim_addr != '0) begin
            busy_d[claim_addr] = 1'b1;
        end
        if (flush) begin
            busy_d = '0;
        end
        busy_d[0] = 1'b0;

        busy_ext = '0;
        busy_ext[DEPTH-1:0] = busy_d;
        busy_cnt_d = (ADDR_W+1)'(popcount(busy_ext));
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int r = 0; r < DEPTH; r++) begin
                regs_q[r] <= '0;
            end
            busy_q     <= '0;
            busy_cnt_q <= '0;
        end else begin
            for (int r = 0; r < DEPTH; r++) begin
                regs_q[r] <= regs_d[r];
            end
            busy_q     <= busy_d;
            busy_cnt_q <= busy_cnt_d;
        end
    end

    assign busy_cnt = busy_cnt_q;

    for (genvar gi = 0; gi < NUM_RD; gi++) begin : g_rd
        logic [ADDR_W-1:0] ra;
        logic              hit;

        assign ra = rd_addr[gi*ADDR_W +: ADDR_W];

        grf_bypass #(
            .DATA_W (DATA_W),
            .ADDR_W (ADDR_W),
            .NUM_WR (NUM_WR)
        ) u_bypass (
            .rd_addr_i     (ra),
            .stored_data_i (regs_q[ra]),
            .wr_en_i       (wr_en),
            .wr_addr_i     (wr_addr),
            .wr_data_i     (wr_data),
            .rd_data_o     (rd_data[gi*DATA_W +: DATA_W]),
            .wr_hit_o      (hit)
        );

        // The bypass already delivers the value, so the reader need not stall.
        assign rd_busy[gi] = busy_q[ra] & ~hit;
    end

endmodule

// File: tb/tb_grf_sb.sv
// Randomised scoreboard bench for grf_sb (2 read ports, 2 write ports).
// A driver pushes reference-model expectations; a negedge monitor pops and compares.
module tb_grf_sb;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [9:0]  rd_addr;
    logic [63:0] rd_data;
    logic [1:0]  rd_busy;
    logic [1:0]  wr_en;
    logic [9:0]  wr_addr;
    logic [63:0] wr_data;
    logic        claim_en;
    logic [4:0]  claim_addr;
    logic        flush;
    logic [5:0]  busy_cnt;

    grf_sb #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2), .NUM_WR(2)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .rd_busy    (rd_busy),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .claim_en   (claim_en),
        .claim_addr (claim_addr),
        .flush      (flush),
        .busy_cnt   (busy_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  ra0, ra1;
        logic [1:0]  we;
        logic [4:0]  wa0, wa1;
        logic [31:0] wd0, wd1;
        logic        ce;
        logic [4:0]  ca;
        logic        fl;
        logic        rst;
    } stim_t;

    typedef struct {
        logic [31:0] d0, d1;
        logic [1:0]  b;
        logic [5:0]  cnt;
        logic [4:0]  ra0, ra1;
    } exp_t;

    exp_t        expq[$];
    int          checks = 0;
    int          errors = 0;
    int          txn    = 0;

    // Architectural reference state.
    logic [31:0] m_regs [32];
    bit          m_busy [32];

    function automatic stim_t mk(input logic [4:0] ra0, input logic [4:0] ra1,
                                 input logic [1:0] we,
                                 input logic [4:0] wa0, input logic [31:0] wd0,
                                 input logic [4:0] wa1, input logic [31:0] wd1,
                                 input logic ce, input logic [4:0] ca,
                                 input logic fl, input logic rst);
        stim_t s;
        s.ra0 = ra0; s.ra1 = ra1; s.we = we;
        s.wa0 = wa0; s.wd0 = wd0; s.wa1 = wa1; s.wd1 = wd1;
        s.ce = ce; s.ca = ca; s.fl = fl; s.rst = rst;
        return s;
    endfunction

    function automatic void model_clear();
        for (int r = 0; r < 32; r++) begin
            m_regs[r] = '0;
            m_busy[r] = 0;
        end
    endfunction

    // Value seen by a reader: newest same-cycle write wins, else stored, r0 is zero.
    function automatic logic [31:0] read_val(input stim_t s, input logic [4:0] ra);
        if (ra == 0) return '0;
        if (s.we[1] && s.wa1 == ra) return s.wd1;
        if (s.we[0] && s.wa0 == ra) return s.wd0;
        return m_regs[ra];
    endfunction

    function automatic logic read_busy(input stim_t s, input logic [4:0] ra);
        bit written;
        written = (ra != 0) && ((s.we[1] && s.wa1 == ra) || (s.we[0] && s.wa0 == ra));
        return m_busy[ra] && !written;
    endfunction

    function automatic exp_t model_expect(input stim_t s);
        exp_t e;
        int   n;
        n = 0;
        for (int r = 0; r < 32; r++) n += int'(m_busy[r]);
        e.d0  = read_val(s, s.ra0);
        e.d1  = read_val(s, s.ra1);
        e.b   = {read_busy(s, s.ra1), read_busy(s, s.ra0)};
        e.cnt = 6'(n);
        e.ra0 = s.ra0;
        e.ra1 = s.ra1;
        return e;
    endfunction

    function automatic void model_edge(input stim_t s);
        if (s.we[0] && s.wa0 != 0) m_regs[s.wa0] = s.wd0;
        if (s.we[1] && s.wa1 != 0) m_regs[s.wa1] = s.wd1;
        if (s.we[0]) m_busy[s.wa0] = 0;
        if (s.we[1]) m_busy[s.wa1] = 0;
        if (s.ce && s.ca != 0) m_busy[s.ca] = 1;
        if (s.fl) for (int r = 0; r < 32; r++) m_busy[r] = 0;
    endfunction

    task automatic step(input stim_t s);
        exp_t e;
        @(posedge clk);
        #1;
        rd_addr    = {s.ra1, s.ra0};
        wr_en      = s.we;
        wr_addr    = {s.wa1, s.wa0};
        wr_data    = {s.wd1, s.wd0};
        claim_en   = s.ce;
        claim_addr = s.ca;
        flush      = s.fl;
        if (s.rst) begin
            reset_n = 1'b0;
            model_clear();
        end
        e = model_expect(s);
        expq.push_back(e);
        if (s.rst) begin
            @(negedge clk);
            #2;
            reset_n = 1'b1;
        end
        model_edge(s);
    endtask

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s txn %0d: got %h expected %h", name, txn, act, req);
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (expq.size() != 0) begin
                e = expq.pop_front();
                cmp("rd_data0", rd_data[31:0], e.d0);
                cmp("rd_data1", rd_data[63:32], e.d1);
                cmp("rd_busy", {30'd0, rd_busy}, {30'd0, e.b});
                cmp("busy_cnt", {26'd0, busy_cnt}, {26'd0, e.cnt});
                $display("txn %0d ra=%0d/%0d rd=%h/%h busy=%b cnt=%0d",
                         txn, e.ra0, e.ra1, rd_data[31:0], rd_data[63:32], rd_busy, busy_cnt);
                txn++;
            end
        end
    end

    function automatic logic [4:0] pick_addr();
        if ($urandom_range(0, 3) == 0) return 5'($urandom_range(0, 31));
        return 5'($urandom_range(0, 7));
    endfunction

    initial begin : driver
        stim_t s;
        reset_n    = 1'b0;
        rd_addr    = '0;
        wr_en      = '0;
        wr_addr    = '0;
        wr_data    = '0;
        claim_en   = 1'b0;
        claim_addr = '0;
        flush      = 1'b0;
        model_clear();
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;

        // Reset state
        step(mk(0, 5, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0));
        step(mk(31, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0));
        // Write with same-cycle bypass, then stored read; write to r0 ignored
        step(mk(7, 7, 2'b01, 7, 32'hDEADBEEF, 0, 0, 0, 0, 0, 0));
        step(mk(7, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0));
        step(mk(0, 0, 2'b01, 0, 32'h1234, 0, 0, 0, 0, 0, 0));
        step(mk(0, 7, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0));
        // Both ports write r3: port 1 wins
        step(mk(3, 3, 2'b11, 3, 32'h11, 3, 32'h22, 0, 0, 0, 0));
        step(mk(3, 7, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0));
        // Scoreboard lifecycle on r9
        step(mk(9, 9, 2'b00, 0, 0, 0, 0, 1, 9, 0, 0));
        step(mk(9, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0));
        step(mk(9, 9, 2'b01, 9, 32'h99, 0, 0, 0, 0, 0, 0));
        step(mk(9, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0));
        step(mk(9, 0, 2'b10, 0, 0, 9, 32'h98, 1, 9, 0, 0));
        step(mk(9, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0));
        step(mk(9, 0, 2'b01, 9, 32'h97, 0, 0, 0, 0, 0, 0));
        // Claim r0 ignored; claims of r1..r3, then flush with claim r4
        step(mk(0, 1, 2'b00, 0, 0, 0, 0, 1, 0, 0, 0));
        step(mk(0, 1, 2'b00, 0, 0, 0, 0, 1, 1, 0, 0));
        step(mk(1, 2, 2'b00, 0, 0, 0, 0, 1, 2, 0, 0));
        step(mk(2, 3, 2'b00, 0, 0, 0, 0, 1, 3, 0, 0));
        step(mk(3, 1, 2'b00, 0, 0, 0, 0, 1, 3, 0, 0));
        step(mk(4, 1, 2'b00, 0, 0, 0, 0, 1, 4, 1, 0));
        step(mk(4, 2, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0));
        // r5 written and busy, then async reset between edges
        step(mk(5, 0, 2'b01, 5, 32'hAA, 0, 0, 1, 5, 0, 0));
        step(mk(5, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0));
        step(mk(5, 7, 2'b00, 0, 0, 0, 0, 0, 0, 0, 1));
        step(mk(5, 7, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0));

        for (int k = 0; k < 400; k++) begin
            s.ra0 = pick_addr();
            s.ra1 = pick_addr();
            s.we  = 2'($urandom_range(0, 3));
            s.wa0 = pick_addr();
            s.wa1 = ($urandom_range(0, 3) == 0) ? s.wa0 : pick_addr();
            s.wd0 = $urandom;
            s.wd1 = $urandom;
            s.ce  = ($urandom_range(0, 1) == 1);
            s.ca  = ($urandom_range(0, 3) == 0) ? s.wa0 : pick_addr();
            s.fl  = ($urandom_range(0, 29) == 0);
            s.rst = ($urandom_range(0, 63) == 0);
            if (s.rst) s.we = 2'b00;
            step(s);
        end

        for (int k = 0; k < 10 && expq.size() != 0; k++) @(negedge clk);
        #1;
        checks++;
        if (expq.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left, expected 0", expq.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
